// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the alarm clock keypad/button sequencer.
package alarm_clock_pkg;

   typedef enum logic [2:0] {
      SHOW_TIME        = 3'd0,
      KEY_STORED       = 3'd1,
      KEY_WAITED       = 3'd2,
      KEY_ENTRY        = 3'd3,
      SHOW_ALARM       = 3'd4,
      SET_ALARM_TIME   = 3'd5,
      SET_CURRENT_TIME = 3'd6
   } alarm_state_t;

   localparam logic [3:0] NOKEY             = 4'd10;
   localparam int         TIMEOUT_S_DEFAULT = 10;

endpackage

// File: rtl/alarm_clock_timeout_cnt.sv
// Keypad-inactivity timer: counts one_second pulses while enabled and flags
// the pulse that completes TIMEOUT_S seconds.
module alarm_clock_timeout_cnt
   import alarm_clock_pkg::*;
#(
   parameter int TIMEOUT_S = TIMEOUT_S_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   input  logic one_second,
   output logic timeout
);

   localparam logic [3:0] LAST_COUNT = 4'(TIMEOUT_S - 1);

   logic [3:0] count;

   assign timeout = en && one_second && (count == LAST_COUNT);

   // Clearing on timeout as well keeps the counter from ever wrapping.
   always_ff @(posedge clk) begin
      if (reset || clr || timeout) begin
         count <= 4'd0;
      end else if (en && one_second) begin
         count <= count + 4'd1;
      end
   end

endmodule

// File: rtl/alarm_clock_fsm.sv
// Keypad and button sequencing controller: Moore FSM driving the key-register
// shift, display select and alarm/current-time load strobes.
module alarm_clock_fsm
   import alarm_clock_pkg::*;
#(
   parameter int TIMEOUT_S = TIMEOUT_S_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       one_second,
   input  logic [3:0] key,
   input  logic       alarm_button,
   input  logic       time_button,
   output logic       shift,
   output logic       show_new_time,
   output logic       show_a,
   output logic       load_new_a,
   output logic       load_new_c
);

   alarm_state_t state;
   alarm_state_t state_next;
   logic         key_valid;
   logic         cnt_en;
   logic         timeout;

   // Codes 10..15 (NOKEY and the unused codes) all read as "no key".
   assign key_valid = (key < NOKEY);
   assign cnt_en    = (state == KEY_WAITED) || (state == KEY_ENTRY);

   alarm_clock_timeout_cnt #(
      .TIMEOUT_S (TIMEOUT_S)
   ) u_timeout_cnt (
      .clk        (clk),
      .reset      (reset),
      .en         (cnt_en),
      .clr        (!cnt_en),
      .one_second (one_second),
      .timeout    (timeout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SHOW_TIME;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         SHOW_TIME: begin
            if (alarm_button)   state_next = SHOW_ALARM;
            else if (key_valid) state_next = KEY_STORED;
         end
         // A single cycle here gives exactly one shift per key press.
         KEY_STORED: state_next = KEY_WAITED;
         KEY_WAITED: begin
            if (timeout)         state_next = SHOW_TIME;
            else if (!key_valid) state_next = KEY_ENTRY;
         end
         KEY_ENTRY: begin
            if (alarm_button)     state_next = SET_ALARM_TIME;
            else if (time_button) state_next = SET_CURRENT_TIME;
            else if (key_valid)   state_next = KEY_STORED;
            else if (timeout)     state_next = SHOW_TIME;
         end
         SHOW_ALARM: begin
            if (!alarm_button) state_next = SHOW_TIME;
         end
         SET_ALARM_TIME:   state_next = SHOW_TIME;
         SET_CURRENT_TIME: state_next = SHOW_TIME;
         default:          state_next = SHOW_TIME;
      endcase
   end

   always_comb begin
      shift         = 1'b0;
      show_new_time = 1'b0;
      show_a        = 1'b0;
      load_new_a    = 1'b0;
      load_new_c    = 1'b0;
      case (state)
         KEY_STORED: begin
            shift         = 1'b1;
            show_new_time = 1'b1;
         end
         KEY_WAITED:       show_new_time = 1'b1;
         KEY_ENTRY:        show_new_time = 1'b1;
         SHOW_ALARM:       show_a        = 1'b1;
         SET_ALARM_TIME:   load_new_a    = 1'b1;
         SET_CURRENT_TIME: load_new_c    = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alarm_clock_fsm.sv
// Self-checking bench for alarm_clock_fsm: each cycle's expected output vector
// is queued when the stimulus is driven and compared after the clock edge.
module tb_alarm_clock_fsm;
   import alarm_clock_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       one_second = 1'b0;
   logic [3:0] key = NOKEY;
   logic       alarm_button = 1'b0;
   logic       time_button = 1'b0;
   logic       shift;
   logic       show_new_time;
   logic       show_a;
   logic       load_new_a;
   logic       load_new_c;

   // Output vector order: {shift, show_new_time, show_a, load_new_a, load_new_c}
   localparam logic [4:0] V_TIME   = 5'b00000;
   localparam logic [4:0] V_STORED = 5'b11000;
   localparam logic [4:0] V_ENTRY  = 5'b01000;
   localparam logic [4:0] V_ALARM  = 5'b00100;
   localparam logic [4:0] V_SETA   = 5'b00010;
   localparam logic [4:0] V_SETC   = 5'b00001;

   logic [4:0] exp_q[$];
   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   int cnt_shift    = 0;
   int cnt_la       = 0;
   int cnt_lc       = 0;

   alarm_clock_fsm #(.TIMEOUT_S(TIMEOUT_S_DEFAULT)) dut (
      .clk           (clk),
      .reset         (reset),
      .one_second    (one_second),
      .key           (key),
      .alarm_button  (alarm_button),
      .time_button   (time_button),
      .shift         (shift),
      .show_new_time (show_new_time),
      .show_a        (show_a),
      .load_new_a    (load_new_a),
      .load_new_c    (load_new_c)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- driver + scoreboard ----------------
   task automatic step(input logic [3:0] k, input logic ab, input logic tb,
                       input logic os, input logic rst, input logic [4:0] e);
      logic [4:0] got;
      logic [4:0] want;
      key          = k;
      alarm_button = ab;
      time_button  = tb;
      one_second   = os;
      reset        = rst;
      exp_q.push_back(e);
      @(posedge clk);
      #3;
      cyc++;
      got  = {shift, show_new_time, show_a, load_new_a, load_new_c};
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("FAIL outputs cycle %0d: got %b expected %b", cyc, got, want);
      end
      cnt_shift += int'(shift);
      cnt_la    += int'(load_new_a);
      cnt_lc    += int'(load_new_c);
   endtask

   task automatic idle(input int n, input logic [4:0] e);
      for (int i = 0; i < n; i++) step(NOKEY, 1'b0, 1'b0, 1'b0, 1'b0, e);
   endtask

   task automatic press(input logic [3:0] k, input int n);
      step(k, 1'b0, 1'b0, 1'b0, 1'b0, V_STORED);
      for (int i = 1; i < n; i++) step(k, 1'b0, 1'b0, 1'b0, 1'b0, V_ENTRY);
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         step(NOKEY, 1'b0, 1'b0, 1'b1, 1'b0, V_ENTRY);
         step(NOKEY, 1'b0, 1'b0, 1'b0, 1'b0, V_ENTRY);
      end
   endtask

   task automatic clear_counts();
      cnt_shift = 0;
      cnt_la    = 0;
      cnt_lc    = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      step(NOKEY, 1'b0, 1'b0, 1'b0, 1'b1, V_TIME);
      step(NOKEY, 1'b0, 1'b0, 1'b0, 1'b1, V_TIME);
      idle(3, V_TIME);
      step(NOKEY, 1'b0, 1'b1, 1'b0, 1'b0, V_TIME);   // time_button ignored here
      step(NOKEY, 1'b0, 1'b0, 1'b1, 1'b0, V_TIME);
   endtask

   task automatic test_reset_mid_entry();
      press(4'd3, 2);
      for (int i = 0; i < 3; i++) step(4'd3, 1'b0, 1'b0, 1'b1, 1'b0, V_ENTRY);
      step(4'd3, 1'b0, 1'b0, 1'b0, 1'b1, V_TIME);
      idle(2, V_TIME);
      press(4'd7, 1);
      idle(1, V_ENTRY);
      pulses(9);
      step(NOKEY, 1'b0, 1'b0, 1'b1, 1'b0, V_TIME);
      idle(1, V_TIME);
   endtask

   task automatic test_time_set();
      clear_counts();
      for (int d = 1; d <= 4; d++) begin
         press(4'(d), 5);
         idle(3, V_ENTRY);
      end
      step(NOKEY, 1'b0, 1'b1, 1'b0, 1'b0, V_SETC);
      step(NOKEY, 1'b0, 1'b1, 1'b0, 1'b0, V_TIME);
      idle(2, V_TIME);
      tests_run++;
      if (cnt_shift !== 4 || cnt_lc !== 1 || cnt_la !== 0) begin
         tests_failed++;
         $display("FAIL time_set counts: shift=%0d lc=%0d la=%0d expected 4 1 0",
                  cnt_shift, cnt_lc, cnt_la);
      end
   endtask

   task automatic test_alarm();
      logic [3:0] digits [4];
      digits = '{4'd0, 4'd7, 4'd3, 4'd0};
      clear_counts();
      for (int i = 0; i < 4; i++) begin
         press(digits[i], 2);
         idle(2, V_ENTRY);
      end
      step(NOKEY, 1'b1, 1'b0, 1'b0, 1'b0, V_SETA);
      step(NOKEY, 1'b0, 1'b0, 1'b0, 1'b0, V_TIME);
      idle(3, V_TIME);
      for (int i = 0; i < 20; i++)
         step((i % 3 == 0) ? 4'd5 : NOKEY, 1'b1, 1'b0, 1'b0, 1'b0, V_ALARM);
      step(NOKEY, 1'b0, 1'b0, 1'b0, 1'b0, V_TIME);
      tests_run++;
      if (cnt_la !== 1 || cnt_lc !== 0 || cnt_shift !== 4) begin
         tests_failed++;
         $display("FAIL alarm counts: la=%0d lc=%0d shift=%0d expected 1 0 4",
                  cnt_la, cnt_lc, cnt_shift);
      end
   endtask

   task automatic test_timeout();
      clear_counts();
      press(4'd5, 2);
      idle(1, V_ENTRY);
      pulses(9);
      step(NOKEY, 1'b0, 1'b0, 1'b1, 1'b0, V_TIME);   // 10th pulse
      idle(2, V_TIME);
      press(4'd5, 2);
      idle(1, V_ENTRY);
      pulses(9);
      press(4'd6, 2);                                 // restarts the count
      idle(1, V_ENTRY);
      pulses(9);
      step(NOKEY, 1'b0, 1'b0, 1'b1, 1'b0, V_TIME);
      idle(1, V_TIME);
      tests_run++;
      if (cnt_la !== 0 || cnt_lc !== 0 || cnt_shift !== 3) begin
         tests_failed++;
         $display("FAIL timeout counts: la=%0d lc=%0d shift=%0d expected 0 0 3",
                  cnt_la, cnt_lc, cnt_shift);
      end
   endtask

   task automatic test_priorities();
      press(4'd2, 2);
      idle(1, V_ENTRY);
      clear_counts();
      step(4'd2, 1'b1, 1'b1, 1'b0, 1'b0, V_SETA);
      step(NOKEY, 1'b0, 1'b0, 1'b0, 1'b0, V_TIME);
      tests_run++;
      if (cnt_la !== 1 || cnt_lc !== 0 || cnt_shift !== 0) begin
         tests_failed++;
         $display("FAIL prio_buttons counts: la=%0d lc=%0d shift=%0d expected 1 0 0",
                  cnt_la, cnt_lc, cnt_shift);
      end
      press(4'd1, 2);
      idle(1, V_ENTRY);
      pulses(9);
      clear_counts();
      step(4'd9, 1'b0, 1'b0, 1'b1, 1'b0, V_STORED);   // key beats timeout
      step(4'd9, 1'b0, 1'b0, 1'b0, 1'b0, V_ENTRY);
      idle(1, V_ENTRY);
      pulses(9);
      step(NOKEY, 1'b0, 1'b0, 1'b1, 1'b0, V_TIME);
      tests_run++;
      if (cnt_shift !== 1) begin
         tests_failed++;
         $display("FAIL prio_key_timeout shift count: got %0d expected 1", cnt_shift);
      end
      step(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, V_ALARM);    // button beats key
      step(NOKEY, 1'b0, 1'b0, 1'b0, 1'b0, V_TIME);
      press(4'd1, 2);
      idle(1, V_ENTRY);
      step(NOKEY, 1'b1, 1'b0, 1'b0, 1'b0, V_SETA);    // held button lands in SHOW_ALARM
      step(NOKEY, 1'b1, 1'b0, 1'b0, 1'b0, V_TIME);
      step(NOKEY, 1'b1, 1'b0, 1'b0, 1'b0, V_ALARM);
      step(NOKEY, 1'b0, 1'b0, 1'b0, 1'b0, V_TIME);
   endtask

   task automatic test_invalid();
      clear_counts();
      for (int i = 0; i < 10; i++) step(4'd12, 1'b0, 1'b0, 1'b0, 1'b0, V_TIME);
      for (int i = 0; i < 3; i++) step(4'(11 + $urandom_range(0, 4)), 1'b0, 1'b0, 1'b0, 1'b0, V_TIME);
      tests_run++;
      if (cnt_shift !== 0) begin
         tests_failed++;
         $display("FAIL invalid_key shift count: got %0d expected 0", cnt_shift);
      end
      press(4'd4, 50);
      tests_run++;
      if (cnt_shift !== 1) begin
         tests_failed++;
         $display("FAIL long_press shift count: got %0d expected 1", cnt_shift);
      end
      step(NOKEY, 1'b0, 1'b0, 1'b0, 1'b1, V_TIME);
   endtask

   task automatic test_back_to_back();
      clear_counts();
      for (int i = 0; i < 6; i++) begin
         press(4'($urandom_range(0, 9)), 1 + $urandom_range(0, 3));
         idle(1 + $urandom_range(0, 2), V_ENTRY);
      end
      step(NOKEY, 1'b0, 1'b1, 1'b0, 1'b0, V_SETC);
      step(NOKEY, 1'b0, 1'b0, 1'b0, 1'b0, V_TIME);
      tests_run++;
      if (cnt_shift !== 6 || cnt_lc !== 1) begin
         tests_failed++;
         $display("FAIL back_to_back counts: shift=%0d lc=%0d expected 6 1",
                  cnt_shift, cnt_lc);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_reset_mid_entry();
      test_time_set();
      test_alarm();
      test_timeout();
      test_priorities();
      test_invalid();
      test_back_to_back();
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
